// File: rtl/lbp_host_if.sv
// Bus bundle joining the LBP host to the pixel stream fabric and the LBP core.
// The host takes the slave modport; the surrounding fabric/core take master.
interface lbp_host_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [DATA_W-1:0] gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [DATA_W-1:0] lbp_data;
  logic              finish;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              done;

  modport master (
    output in_valid, in_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
           finish, out_ready,
    input  in_ready, gray_ready, gray_data, out_valid, out_data, done
  );

  modport slave (
    input  in_valid, in_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
           finish, out_ready,
    output in_ready, gray_ready, gray_data, out_valid, out_data, done
  );
endinterface

// File: rtl/lbp_host.sv
// Frame host for the LBP core: loads an image, serves core reads, captures results, drains them.
// Optional LBP_HOST_CLEAR_EN adds a CLEAR state that zeroes the result buffer before each load.
module lbp_host #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_PIX  = 16384
) (
  input logic       clk,
  input logic       reset,
  lbp_host_if.slave bus
);
  localparam int unsigned      CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_PIX - 1);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_PIX);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [2:0] {S_LOAD, S_SERVE, S_DRAIN, S_DONE, S_CLEAR} state_t;
`ifdef LBP_HOST_CLEAR_EN
  localparam state_t IDLE = S_CLEAR;
`else
  localparam state_t IDLE = S_LOAD;
`endif

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_load_cnt, r_rd_cnt, r_tx_cnt;
`ifdef LBP_HOST_CLEAR_EN
  logic [CNT_W-1:0]  r_clr_cnt;
`endif
  logic              r_in_ready, r_gray_ready, r_done;
  logic              w_in_ready_nxt, w_gray_ready_nxt, w_done_nxt;
  logic [DATA_W-1:0] r_gray_data, r_out_data, r_pf;
  logic              r_out_valid, r_pf_vld;
  logic [DATA_W-1:0] r_image  [N_PIX];
  logic [DATA_W-1:0] r_result [N_PIX];
  logic              w_img_we, w_res_we, w_out_take, w_out_load, w_rd;
  logic [ADDR_W-1:0] w_res_addr;
  logic [DATA_W-1:0] w_res_data;

  // Drain pipeline: result RAM -> prefetch register -> output register.
  assign w_img_we   = (r_state == S_LOAD) & bus.in_valid & r_in_ready;
  assign w_out_take = r_out_valid & bus.out_ready;
  assign w_out_load = r_pf_vld & (~r_out_valid | bus.out_ready);
  assign w_rd       = (r_state == S_DRAIN) & (r_rd_cnt < N_CNT) & (~r_pf_vld | w_out_load);

  always_comb begin
    w_res_we   = (r_state == S_SERVE) & bus.lbp_valid;
    w_res_addr = bus.lbp_addr;
    w_res_data = bus.lbp_data;
`ifdef LBP_HOST_CLEAR_EN
    if (r_state == S_CLEAR) begin
      w_res_we   = 1'b1;
      w_res_addr = r_clr_cnt[ADDR_W-1:0];
      w_res_data = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_img_we && r_load_cnt == LAST) w_state_nxt = S_SERVE;
      S_SERVE: if (bus.finish) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_out_take && r_tx_cnt == LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = IDLE;
`ifdef LBP_HOST_CLEAR_EN
      S_CLEAR: if (r_clr_cnt == LAST) w_state_nxt = S_LOAD;
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they change on the transition edge.
  always_comb begin
    w_in_ready_nxt   = 1'b0;
    w_gray_ready_nxt = 1'b0;
    w_done_nxt       = 1'b0;
    case (w_state_nxt)
      S_LOAD:  w_in_ready_nxt   = 1'b1;
      S_SERVE: w_gray_ready_nxt = 1'b1;
      S_DONE:  w_done_nxt       = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready   <= 1'b0;
      r_gray_ready <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_in_ready   <= w_in_ready_nxt;
      r_gray_ready <= w_gray_ready_nxt;
      r_done       <= w_done_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_cnt <= '0;
      r_rd_cnt   <= '0;
      r_tx_cnt   <= '0;
`ifdef LBP_HOST_CLEAR_EN
      r_clr_cnt  <= '0;
`endif
    end else if (r_state == S_DONE) begin
      r_load_cnt <= '0;
      r_rd_cnt   <= '0;
      r_tx_cnt   <= '0;
`ifdef LBP_HOST_CLEAR_EN
      r_clr_cnt  <= '0;
`endif
    end else begin
      if (w_img_we)   r_load_cnt <= r_load_cnt + ONE;
      if (w_rd)       r_rd_cnt   <= r_rd_cnt + ONE;
      if (w_out_take) r_tx_cnt   <= r_tx_cnt + ONE;
`ifdef LBP_HOST_CLEAR_EN
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + ONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_img_we) r_image[r_load_cnt[ADDR_W-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (w_res_we) r_result[w_res_addr] <= w_res_data;
    if (w_rd)     r_pf <= r_result[r_rd_cnt[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gray_data <= '0;
      r_pf_vld    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (r_state == S_SERVE && bus.gray_req) r_gray_data <= r_image[bus.gray_addr];
      if (w_rd)            r_pf_vld <= 1'b1;
      else if (w_out_load) r_pf_vld <= 1'b0;
      if (w_out_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_pf;
      end else if (w_out_take) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.gray_ready = r_gray_ready;
  assign bus.gray_data  = r_gray_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_lbp_host.sv
// Directed testbench for lbp_host: load, read port, result capture, drain, backpressure, reset.
module tb_lbp_host;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;
  localparam int          N_PIX  = 16384;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lbp_host_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  lbp_host #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_PIX(N_PIX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_res [N_PIX];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.gray_req  = 1'b0;
    bus.gray_addr = '0;
    bus.lbp_valid = 1'b0;
    bus.lbp_addr  = '0;
    bus.lbp_data  = '0;
    bus.finish    = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // Streams a full frame at one pixel per cycle; pixel i carries i[7:0] ^ mask.
  task automatic load_frame(input logic [7:0] mask);
    int   i   = 0;
    int   cyc = 0;
    logic acc;
    while (i < N_PIX && cyc < 40000) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i) ^ mask;
      acc = (bus.in_ready === 1'b1);
      tick();
      cyc++;
      if (acc) i++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    int exp_cyc;
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    n_checks++; if (bus.gray_ready !== 1'b0) begin n_fail++; $display("FAIL reset_gray_ready got=%b exp=0", bus.gray_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_checks++; if (bus.gray_data !== 8'h00) begin n_fail++; $display("FAIL reset_gray_data got=%h exp=00", bus.gray_data); end
    n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
    reset = 1'b0;
    cyc   = 0;
    while (bus.in_ready !== 1'b1 && cyc < 20000) begin
      tick();
      cyc++;
    end
`ifdef LBP_HOST_CLEAR_EN
    exp_cyc = N_PIX;
`else
    exp_cyc = 1;
`endif
    n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL reset_first_ready cycles=%0d exp=%0d", cyc, exp_cyc); end
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5A;
      tick();
    end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_in_ready got=%b exp=0", bus.in_ready); end
    n_checks++; if (bus.gray_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_flags got=%b%b%b exp=000", bus.gray_ready, bus.out_valid, bus.done);
    end
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_reload_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_load();
    int   i   = 0;
    int   cyc = 0;
    logic acc;
    // First 1024 pixels arrive on alternate cycles, the rest back to back.
    while (i < N_PIX && cyc < 40000) begin
      bus.in_valid = (i >= 1024) || (cyc[0] == 1'b1);
      bus.in_data  = 8'(i);
      acc = bus.in_valid && (bus.in_ready === 1'b1);
      if (acc && i == N_PIX - 1) begin
        n_checks++; if (bus.gray_ready !== 1'b0) begin n_fail++; $display("FAIL load_gray_ready_early got=%b exp=0", bus.gray_ready); end
      end
      tick();
      cyc++;
      if (acc) i++;
    end
    bus.in_valid = 1'b0;
    n_checks++; if (cyc !== 17408) begin n_fail++; $display("FAIL load_cycles got=%0d exp=17408", cyc); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL load_in_ready_drop got=%b exp=0", bus.in_ready); end
    n_checks++; if (bus.gray_ready !== 1'b1) begin n_fail++; $display("FAIL load_gray_ready_rise got=%b exp=1", bus.gray_ready); end
  endtask

  task automatic test_read_port();
    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'h1234;
    tick();
    n_checks++; if (bus.gray_data !== 8'h34) begin n_fail++; $display("FAIL read_1234 got=%h exp=34", bus.gray_data); end
    bus.gray_addr = 14'd0;
    tick();
    n_checks++; if (bus.gray_data !== 8'h00) begin n_fail++; $display("FAIL read_0 got=%h exp=00", bus.gray_data); end
    bus.gray_addr = 14'd255;
    tick();
    n_checks++; if (bus.gray_data !== 8'hFF) begin n_fail++; $display("FAIL read_255 got=%h exp=ff", bus.gray_data); end
    bus.gray_addr = 14'd16383;
    tick();
    n_checks++; if (bus.gray_data !== 8'hFF) begin n_fail++; $display("FAIL read_16383 got=%h exp=ff", bus.gray_data); end
    bus.gray_req  = 1'b0;
    bus.gray_addr = 14'd16;
    repeat (2) tick();
    n_checks++; if (bus.gray_data !== 8'hFF) begin n_fail++; $display("FAIL read_hold got=%h exp=ff", bus.gray_data); end
  endtask

  task automatic test_write_drain();
    int errs  = 0;
    int gaps  = 0;
    int first = -1;
    for (int i = 0; i < N_PIX; i++) begin
      bus.lbp_valid = 1'b1;
      bus.lbp_addr  = 14'(i);
      bus.lbp_data  = ~8'(i);
      exp_res[i]    = ~8'(i);
      tick();
    end
    bus.lbp_addr = 14'd7; bus.lbp_data = 8'h11; tick();
    bus.lbp_addr = 14'd7; bus.lbp_data = 8'h22; tick();
    exp_res[7] = 8'h22;
    // Result write coincides with finish and must still land.
    bus.lbp_addr  = 14'd5;
    bus.lbp_data  = 8'h55;
    bus.finish    = 1'b1;
    bus.out_ready = 1'b1;
    exp_res[5]    = 8'h55;
    tick();
    bus.lbp_valid = 1'b0;
    bus.finish    = 1'b0;
    n_checks++; if (bus.gray_ready !== 1'b0) begin n_fail++; $display("FAIL drain_gray_ready got=%b exp=0", bus.gray_ready); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_early_valid got=%b exp=0", bus.out_valid); end
    tick();
    for (int k = 0; k < N_PIX; k++) begin
      if (bus.out_valid !== 1'b1) gaps++;
      if (bus.out_data !== exp_res[k]) begin
        if (first < 0) first = k;
        errs++;
      end
      tick();
    end
    n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL drain_gaps got=%0d exp=0", gaps); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL drain_data errors=%0d first_idx=%0d exp=0", errs, first); end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL drain_done got=%b exp=1", bus.done); end
    tick();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL drain_done_pulse got=%b exp=0", bus.done); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_back_to_load got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_backpressure();
    int         k    = 0;
    int         cyc  = 0;
    int         errs = 0;
    int         stab = 0;
    logic       hold = 1'b0;
    logic [7:0] prev = '0;
    // Result writes during LOAD must be dropped, so address 9 keeps its previous-frame value.
    bus.out_ready = 1'b0;
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'd9;
    bus.lbp_data  = 8'h99;
    load_frame(8'h3C);
    bus.lbp_valid = 1'b0;
    n_checks++; if (bus.gray_ready !== 1'b1) begin n_fail++; $display("FAIL bp_gray_ready got=%b exp=1", bus.gray_ready); end
    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'd10;
    tick();
    bus.gray_req  = 1'b0;
    n_checks++; if (bus.gray_data !== 8'h36) begin n_fail++; $display("FAIL bp_read_10 got=%h exp=36", bus.gray_data); end
    bus.finish = 1'b1;
    tick();
    bus.finish = 1'b0;
    while (k < N_PIX && cyc < 40000) begin
      if (hold && (bus.out_valid !== 1'b1 || bus.out_data !== prev)) stab++;
      bus.out_ready = (cyc < 2048) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        if (bus.out_data !== exp_res[k]) errs++;
        k++;
      end
      hold = (bus.out_valid === 1'b1) && !bus.out_ready;
      prev = bus.out_data;
      tick();
      cyc++;
    end
    n_checks++; if (k !== N_PIX) begin n_fail++; $display("FAIL bp_count got=%0d exp=%0d", k, N_PIX); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL bp_data errors=%0d exp=0", errs); end
    n_checks++; if (stab !== 0) begin n_fail++; $display("FAIL bp_stall_stable violations=%0d exp=0", stab); end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL bp_done got=%b exp=1", bus.done); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL bp_after_done got=%b%b exp=00", bus.out_valid, bus.done);
    end
  endtask

`ifdef LBP_HOST_CLEAR_EN
  task automatic test_clear();
    int errs = 0;
    int cyc  = 0;
    load_frame(8'h00);
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'd0;
    bus.lbp_data  = 8'hAA;
    tick();
    bus.lbp_valid = 1'b0;
    bus.finish    = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.finish = 1'b0;
    while (bus.out_valid !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    for (int k = 0; k < N_PIX; k++) begin
      if (bus.out_valid !== 1'b1 || bus.out_data !== ((k == 0) ? 8'hAA : 8'h00)) errs++;
      tick();
    end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL clear_drain errors=%0d exp=0", errs); end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL clear_done got=%b exp=1", bus.done); end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
`ifdef LBP_HOST_CLEAR_EN
    test_clear();
`else
    test_reset_midload();
    test_load();
    test_read_port();
    test_write_drain();
    test_backpressure();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lbp_host.md
# lbp_host

Frame-level host for the LBP core: accepts a 128x128 grayscale image as a pixel stream into an internal image buffer, then acts as the memory responder on the core's `gray_req`/`gray_addr`/`gray_data` read port. It also captures the core's `lbp_valid`/`lbp_addr`/`lbp_data` writes into an internal result buffer. After `finish`, it streams the result image out. It is the synthesizable counterpart of the bench-side gray memory and result memory, and sits between the SoC stream fabric and the LBP core.

## Interface
- `ADDR_W`, 14, address width of both buffers.
- `DATA_W`, 8, pixel width.
- `N_PIX`, 16384, pixels per frame; must equal 2^`ADDR_W`.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: input pixel valid.
- `in_data` input DATA_W: input pixel, raster order starting at address 0.
- `in_ready` output 1: host accepts an input pixel.
- `gray_ready` output 1: image loaded; the core may issue reads.
- `gray_req` input 1: read request from the core.
- `gray_addr` input ADDR_W: read address.
- `gray_data` output DATA_W: read data, registered.
- `lbp_valid` input 1: result write strobe.
- `lbp_addr` input ADDR_W: result write address.
- `lbp_data` input DATA_W: result write data.
- `finish` input 1: core has completed the frame.
- `out_valid` output 1: result pixel valid.
- `out_data` output DATA_W: result pixel, registered, in address order.
- `out_ready` input 1: downstream accepts a result pixel.
- `done` output 1: one-cycle pulse after the last result pixel transfers.

## Operation
- States: LOAD, SERVE, DRAIN, DONE, plus CLEAR when `LBP_HOST_CLEAR_EN` is defined.
- **LOAD**
  - `in_ready`=1.
  - Each cycle with `in_valid & in_ready` writes `in_data` to image[`load_cnt`] and increments `load_cnt`.
  - When the transfer at `load_cnt`=N_PIX-1 completes, the block goes to SERVE and `in_ready` drops in the same edge.
- **SERVE**
  - `gray_ready`=1 and `in_ready`=0.
  - A `gray_req` sampled high at edge N loads `gray_data` <= image[`gray_addr`] at edge N.
  - `gray_data` holds that value until the next sampled request.
  - `gray_req` low leaves `gray_data` unchanged; the output is never driven to Z.
- **Result writes**
  - Any cycle with `lbp_valid` in SERVE writes result[`lbp_addr`] <= `lbp_data`.
  - Repeated writes to the same address: last write wins.
  - `lbp_valid` in any other state is ignored.
- **SERVE to DRAIN:** `finish` sampled high moves the block to DRAIN. A `lbp_valid` write in that same cycle is still committed.
- **DRAIN**
  - `gray_ready`=0.
  - Result entries 0..N_PIX-1 are presented in order.
  - The transfer condition is `out_valid & out_ready`.
  - `out_data`/`out_valid` hold while `out_ready`=0.
  - With `out_ready` held high, throughput is one pixel per cycle, using an internal prefetch register.
- **DONE:** entered after the N_PIX-th transfer. `done`=1 for exactly one cycle, then the block returns to LOAD (or CLEAR) with all counters at 0.
- Ignored inputs: `finish` outside SERVE, `gray_req` outside SERVE (`gray_data` unchanged), and `in_valid` outside LOAD.
- Counters are ADDR_W+1 bits wide. Addresses wrap naturally; no out-of-range address exists.

## Timing
- **Reset values:**
  - `in_ready`, `gray_ready`, `out_valid` and `done` are 0.
  - `gray_data` and `out_data` are 0.
  - State is LOAD (or CLEAR) and counters are 0.
  - Buffer contents are not reset.
- **First cycle after reset deassertion:** `in_ready`=1 in LOAD.
- **Frame load time:** minimum N_PIX cycles; `gray_ready` rises the edge after the last pixel is accepted.
- **Read latency:** 1 cycle from the sampled `gray_req` to valid `gray_data`. Back-to-back requests are served every cycle.
- **Write latency:** the result write is visible to DRAIN from the next cycle.
- **Drain start:** first `out_valid` is 2 cycles after `finish` is sampled.
- **Minimum drain time:** N_PIX+1 cycles.
- **Reset mid-operation:** asynchronous return to reset values. A partial frame is discarded and a new load starts at address 0.

## Configuration
- `LBP_HOST_CLEAR_EN` defined:
  - CLEAR state is entered after reset and after DONE.
  - It writes 0 to result[0..N_PIX-1], one entry per cycle, with `in_ready`=0.
  - LOAD is entered after N_PIX cycles.
  - Unwritten result pixels therefore drain as 0.
- `LBP_HOST_CLEAR_EN` undefined: there is no CLEAR state, and unwritten result entries drain with stale or unknown contents.

## Test plan
- **Load handshake:** stream 16384 pixels with value = addr[7:0], `in_valid` toggling every other cycle. Required: `in_ready` drops and `gray_ready` rises exactly one edge after the 16384th accept.
- **Read port:** in SERVE, request addresses 0, 255, 16383 back-to-back. Required: `gray_data` = 0x00, 0xFF, 0xFF on the cycles following each request. With `gray_req` low, `gray_data` holds 0xFF.
- **Write and drain:** write result[i] = ~i[7:0] for all i, then assert `finish` with `out_ready`=1. Required: 16384 transfers in 16384 consecutive cycles, values ~i[7:0], then a single `done` pulse.
- **Backpressure:** drive `out_ready` with a random 50% pattern during DRAIN. Required: no pixel dropped or duplicated, and `out_data` stable while `out_valid` & !`out_ready`.
- **Corner cases:**
  - `lbp_valid` to address 5 in the same cycle as `finish` is drained.
  - Two writes to address 7 (0x11 then 0x22) drain 0x22.
  - `lbp_valid` during LOAD is ignored.
- **Reset and clear:**
  - Assert `reset` mid-LOAD at pixel 100. Required: all outputs return to reset values, and reload restarts at address 0.
  - With `LBP_HOST_CLEAR_EN`, a frame writing only address 0 = 0xAA drains 0xAA followed by 16383 zeros.
